// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with tear-free frame commit,
// dead-time, blinking, and optional leading-zero blanking (HEX_SCAN_LEADING_ZERO_BLANK_EN).

module hexled (
    input  logic [6:0] val,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (val)
            7'd0:  seg = 7'h40;
            7'd1:  seg = 7'h79;
            7'd2:  seg = 7'h24;
            7'd3:  seg = 7'h30;
            7'd4:  seg = 7'h19;
            7'd5:  seg = 7'h12;
            7'd6:  seg = 7'h02;
            7'd7:  seg = 7'h78;
            7'd8:  seg = 7'h00;
            7'd9:  seg = 7'h10;
            7'd10: seg = 7'h08;
            7'd11: seg = 7'h03;
            7'd12: seg = 7'h46;
            7'd13: seg = 7'h21;
            7'd14: seg = 7'h06;
            7'd15: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module hex_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned DEAD         = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [31:0]           i_wr_data,
    input  logic [NUM_DIGITS-1:0] i_blink_mask,
    output logic [6:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_pending,
    output logic                  o_frame_done
);
    localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CMAX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD > 0) ? DEAD - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);

    typedef enum logic {S_DEAD, S_DRIVE} state_t;
    localparam state_t RST_STATE = (DEAD == 0) ? S_DRIVE : S_DEAD;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [FW-1:0]   fcnt, fcnt_nxt;
    logic            phase, phase_nxt;
    logic [31:0]     shadow, shadow_nxt;
    logic [31:0]     disp, disp_nxt;
    logic            pending, pending_nxt;
    logic            frame_done;
    logic [NUM_DIGITS-1:0] an_q, an_nxt;
    logic [6:0]      seg_q, seg_nxt;
    logic [3:0]      nib;
    logic [6:0]      dec_seg;
    logic            blank;

    assign frame_done   = (state == S_DRIVE) && (cnt == PRE_LAST) && (idx == IDX_LAST);
    assign o_frame_done = frame_done;
    assign o_pending    = pending;
    assign o_an         = an_q;
    assign o_seg        = seg_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        case (state)
            S_DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt == PRE_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    state_nxt = (DEAD == 0) ? S_DRIVE : S_DEAD;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // Commit takes the old shadow; a write in the same cycle re-arms pending.
    always_comb begin
        shadow_nxt  = i_wr_en ? i_wr_data : shadow;
        disp_nxt    = disp;
        pending_nxt = pending;
        if (frame_done && pending) begin
            disp_nxt    = shadow;
            pending_nxt = 1'b0;
        end
        if (i_wr_en)
            pending_nxt = 1'b1;

        fcnt_nxt  = fcnt;
        phase_nxt = phase;
        if (frame_done) begin
            if (fcnt == FR_LAST) begin
                fcnt_nxt  = '0;
                phase_nxt = ~phase;
            end else begin
                fcnt_nxt = fcnt + FW'(1);
            end
        end
    end

    // Outputs are decoded from next-cycle values so they register in step with the state.
    always_comb begin
        nib = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++)
            if (idx_nxt == IW'(k))
                nib = disp_nxt[4*k +: 4];
    end

    hexled u_dec (
        .val ({3'b000, nib}),
        .seg (dec_seg)
    );

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++)
            if (disp_nxt[4*k +: 4] != 4'h0)
                msd = IW'(k);
    end
    assign blank = (idx_nxt > msd) || (phase_nxt && i_blink_mask[idx_nxt]);
`else
    assign blank = phase_nxt && i_blink_mask[idx_nxt];
`endif

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        if (state_nxt == S_DRIVE) begin
            an_nxt[idx_nxt] = 1'b0;
            seg_nxt         = blank ? 7'h7F : dec_seg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= RST_STATE;
            cnt     <= '0;
            idx     <= '0;
            fcnt    <= '0;
            phase   <= 1'b0;
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            fcnt    <= fcnt_nxt;
            phase   <= phase_nxt;
            shadow  <= shadow_nxt;
            disp    <= disp_nxt;
            pending <= pending_nxt;
            an_q    <= an_nxt;
            seg_q   <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: cycle-position reference model plus directed and random stimulus.

module tb_hex_scan_ctrl;
    localparam int N  = 8;
    localparam int PS = 4;
    localparam int DD = 2;
    localparam int BF = 2;
    localparam int SLOT = PS + DD;
    localparam int FL = N * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  mask = '0;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        pending;
    logic        frame_done;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS   (N),
        .PRESCALE     (PS),
        .DEAD         (DD),
        .BLINK_FRAMES (BF)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .i_blink_mask (mask),
        .o_seg        (seg),
        .o_an         (an),
        .o_pending    (pending),
        .o_frame_done (frame_done)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference state: cycles since reset, completed frames, register contents.
    int unsigned t = 0;
    int unsigned f = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_disp = '0;
    logic        m_pend = 1'b0;
    logic [7:0]  m_mask_prev = '0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic expect_now(output logic [7:0] e_an, output logic [6:0] e_seg, output logic e_fd);
        int unsigned p, d, s, msd;
        logic [3:0] nibv;
        logic bl;
        p = t % FL;
        d = p / SLOT;
        s = p % SLOT;
        e_fd = (p == FL - 1);
        if (s < DD) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
        end else begin
            e_an = ~(8'h01 << d);
            nibv = 4'((m_disp >> (4 * d)) & 32'hF);
            bl = 1'b0;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
            msd = 0;
            for (int k = 1; k < N; k++)
                if (((m_disp >> (4 * k)) & 32'hF) != 0) msd = k;
            if (d > msd) bl = 1'b1;
`else
            msd = 0;
`endif
            if (((f / BF) % 2 == 1) && m_mask_prev[d]) bl = 1'b1;
            e_seg = bl ? 7'h7F : segtab[nibv];
        end
    endtask

    task automatic tick();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_fd;
        expect_now(e_an, e_seg, e_fd);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        if (rst) begin
            t = 0; f = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
        end else begin
            if (e_fd && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (e_fd) f++;
            if (wr_en) begin
                m_shadow = wr_data;
                m_pend = 1'b1;
            end
            t++;
        end
        m_mask_prev = mask;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int unsigned pp);
        do tick(); while ((t % FL) != pp);
    endtask

    task automatic write(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        goto(2);
        chk("rst_dig0_an", 32'(an), 32'h0FE);
        chk("rst_dig0_seg", 32'(seg), 32'h40);

        goto(20);
        write(32'h89ABCDEF);
        chk("wr_pending", 32'(pending), 32'h1);
        goto(2);
        chk("commit_dig0_F", 32'(seg), 32'h0E);
        goto(44);
        chk("commit_dig7_8", 32'(seg), 32'h00);
        chk("commit_pending", 32'(pending), 32'h0);

        goto(10);
        write(32'h11111111);
        write(32'h22222222);
        goto(2);
        goto(20);
        chk("last_write_wins", 32'(seg), 32'h24);

        goto(10);
        write(32'h3);
        goto(47);
        write(32'h5);
        goto(2);
        chk("fd_write_old", 32'(seg), 32'h30);
        chk("fd_write_pend", 32'(pending), 32'h1);
        goto(2);
        chk("fd_write_new", 32'(seg), 32'h12);
        chk("fd_write_pend0", 32'(pending), 32'h0);

        mask = 8'h01;
        for (int i = 0; i < 8; i++) goto(0);
        mask = 8'h00;

        goto(10);
        write(32'h00000A05);
        goto(2);
        goto(2);
        chk("a05_dig0", 32'(seg), 32'h12);
        goto(8);
        chk("a05_dig1", 32'(seg), 32'h40);
        goto(14);
        chk("a05_dig2", 32'(seg), 32'h08);
        goto(20);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        chk("a05_dig3", 32'(seg), 32'h7F);
`else
        chk("a05_dig3", 32'(seg), 32'h40);
`endif
        goto(10);
        write(32'h0);
        goto(2);
        goto(2);
        chk("zero_dig0", 32'(seg), 32'h40);
        goto(0);

        goto(10);
        write(32'hDEADBEEF);
        goto(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) goto(0);

        for (int i = 0; i < 40 * FL; i++) begin
            wr_en = ($urandom_range(0, 19) == 0);
            wr_data = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 47) == 0) mask = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
